coef_stream_buf: RTL and testbench
==================================

Name: coef_stream_buf

Overview:
- Parametrised, writable coefficient store: successor to the fixed 40-entry combinational coefficient tables.
- Coefficients are loaded through a write port, then streamed as bursts over a valid/ready interface.
- Feeds BWN/FFT datapaths that consume one signed coefficient per cycle from a programmable base address and length, with wrap-around.

Parameters:
- DATA_W, 16, coefficient width (signed two's complement).
- DEPTH, 40, number of coefficient entries (need not be a power of 2).
- ADDR_W, 6, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the load port.
- wr_addr  in  ADDR_W  write address; writes with wr_addr >= DEPTH are dropped.
- wr_data  in  DATA_W  write data.
- rd_start  in  1  burst request pulse; sampled only in IDLE.
- rd_base  in  ADDR_W  burst start address; values >= DEPTH are taken modulo DEPTH by subtracting DEPTH once.
- rd_len  in  ADDR_W+1  burst length; 0 ignored; values > DEPTH clamped to DEPTH.
- rd_busy  out  1  high while a burst is active.
- coef_valid  out  1  output beat valid.
- coef_ready  in  1  consumer ready.
- coef_data  out  DATA_W  coefficient.
- coef_last  out  1  marks the final beat of a burst.

Behaviour:
- Reset (async, active-high):
  - all memory entries = 0; state = IDLE.
  - rd_busy = 0, coef_valid = 0, coef_data = 0, coef_last = 0.
  - Reset asserted mid-burst aborts the burst immediately; there is no resume.
- Storage is a register array.
  - Write takes effect at the clock edge.
  - A read and a write to the same address at the same edge return OLD data (read-before-write).
  - Writes are accepted in any state.
- FSM states: IDLE, STREAM.
  - IDLE -> STREAM at edge N when rd_start = 1 and rd_len != 0.
    - Latches ptr = rd_base (reduced) and remaining = min(rd_len, DEPTH).
    - rd_busy = 1 after edge N.
  - rd_start while in STREAM is ignored; rd_start with rd_len = 0 is ignored in every state.
  - STREAM -> IDLE at the edge where the beat with coef_last = 1 is accepted (coef_valid & coef_ready).
    - rd_busy = 0 and coef_valid = 0 after that edge, unless a new beat is loaded.
    - A new rd_start is accepted in the first IDLE cycle.
- Output register:
  - Loads when (remaining != 0) and (!coef_valid || coef_ready): coef_data <= mem[ptr], coef_valid <= 1, coef_last <= (remaining == 1).
  - On load: ptr <= (ptr == DEPTH-1) ? 0 : ptr+1; remaining <= remaining-1.
  - With coef_valid = 1 and coef_ready = 0, coef_data and coef_last hold stable.
- Latency: first beat has coef_valid = 1 after edge N+1, giving 2 edges from rd_start to the first beat.
- Throughput: 1 beat/cycle while coef_ready = 1.
- Wrap-around: addresses run base, ..., DEPTH-1, 0, 1, ...
  - A burst of length DEPTH returns every entry exactly once.

Optional Feature:
- Macro: COEF_SAT_SHIFT_EN.
- Defined:
  - Adds input rd_shift (3 bits), latched with rd_start.
  - Each coefficient is arithmetically left-shifted by rd_shift before the output register, saturating to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - Latency is unchanged.
- Undefined: the port is absent and coef_data is the raw stored value.

Decomposition:
- Package coef_buf_pkg holds:
  - the state enum (IDLE, STREAM);
  - a function returning the saturation limits for DATA_W;
  - the shift-width constant (3).
- One sub-module: coef_sat_shl, a combinational signed shift-left with saturation.
  - Instantiated only under COEF_SAT_SHIFT_EN.

Test Plan:
- Reset then burst: rst, then rd_start, base 0, len 4, ready = 1 -> four beats of 'h0000; coef_last on beat 4; rd_busy falls after the last handshake.
- Load and latency: write 'h0010, 'h0003, 'h0017, 'hfffc to addresses 0..3; pulse rd_start (base 0, len 4) at edge N -> coef_valid first high after N+1; data 'h0010, 'h0003, 'h0017, 'hfffc on consecutive cycles.
- Wrap and backpressure: DEPTH 40 with addr i holding i; base 38, len 5, ready toggled 1,0,0,1,... -> data 38, 39, 0, 1, 2; coef_data stable while ready = 0; last on value 2.
- Boundaries:
  - len 0 -> no beats, rd_busy stays 0;
  - len 63 -> clamped to 40 beats;
  - rd_start mid-burst -> ignored;
  - write at a wr_addr equal to the next fetched address on the same edge -> old value is output.
- Reset mid-burst: assert rst after beat 2 of 6 -> coef_valid = 0 and rd_busy = 0 immediately; memory is 0 afterwards.
- COEF_SAT_SHIFT_EN: entries 'h003e and 'hff7f, rd_shift 3 -> 'h01f0 and 'hfbf8; entry 'h4000 with shift 1 -> 'h7fff; entry 'h8000 with shift 1 -> 'h8000.

Source files
------------

// File: rtl/coef_buf_pkg.sv
// Shared types and constants for the coefficient stream buffer.
// The saturating shift (macro COEF_SAT_SHIFT_EN) uses SHIFT_W and sat_limits.
package coef_buf_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Width of the per-burst left-shift amount.
    localparam int SHIFT_W = 3;

    typedef struct packed {
        logic signed [63:0] lo;
        logic signed [63:0] hi;
    } sat_lim_t;

    // Most negative and most positive two's complement values of width w.
    function automatic sat_lim_t sat_limits(input int unsigned w);
        sat_lim_t l;
        l.hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        l.lo = -(64'sd1 <<< (w - 1));
        return l;
    endfunction

endpackage

// File: rtl/coef_sat_shl.sv
// Combinational signed shift-left with saturation to the DATA_W range.
// Only present in builds with COEF_SAT_SHIFT_EN defined.
`ifdef COEF_SAT_SHIFT_EN
module coef_sat_shl
    import coef_buf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0]  din,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [DATA_W-1:0]  dout
);

    // Wide enough to hold the largest shift without losing the sign.
    localparam int WIDE_W = DATA_W + (1 << SHIFT_W);
    localparam sat_lim_t LIM = sat_limits(DATA_W);
    localparam logic signed [WIDE_W-1:0] HI = WIDE_W'(LIM.hi);
    localparam logic signed [WIDE_W-1:0] LO = WIDE_W'(LIM.lo);

    logic signed [WIDE_W-1:0] wide;

    // Shift at full precision, then clamp into the output range.
    always_comb begin
        wide = WIDE_W'(din) <<< shift;
        if (wide > HI) begin
            dout = DATA_W'(HI);
        end else if (wide < LO) begin
            dout = DATA_W'(LO);
        end else begin
            dout = wide[DATA_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/coef_stream_buf.sv
// Writable coefficient store streamed as wrap-around bursts over valid/ready.
// Optional macro COEF_SAT_SHIFT_EN adds a per-burst saturating left shift.
module coef_stream_buf
    import coef_buf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 40,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic        [ADDR_W-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_start,
    input  logic        [ADDR_W-1:0] rd_base,
    input  logic        [ADDR_W:0]   rd_len,
`ifdef COEF_SAT_SHIFT_EN
    input  logic       [SHIFT_W-1:0] rd_shift,
`endif
    output logic                     rd_busy,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [DATA_W-1:0] coef_data,
    output logic                     coef_last
);

    // DEPTH_A wraps to 0 when DEPTH == 2**ADDR_W, which makes the base
    // reduction a no-op, exactly as required in that case.
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH % (2 ** ADDR_W));
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic [ADDR_W:0]          rem_q, rem_d;
    logic                     coef_valid_q, coef_valid_d;
    logic                     coef_last_q, coef_last_d;
    logic signed [DATA_W-1:0] coef_data_q, coef_data_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] mem_d [DEPTH];

    logic                     start;
    logic                     load;
    logic [ADDR_W-1:0]        base_red;
    logic [ADDR_W:0]          len_clamp;
    logic signed [DATA_W-1:0] fetched;
    logic signed [DATA_W-1:0] out_val;

`ifdef COEF_SAT_SHIFT_EN
    logic [SHIFT_W-1:0] shift_q, shift_d;

    coef_sat_shl #(
        .DATA_W (DATA_W)
    ) u_sat_shl (
        .din   (fetched),
        .shift (shift_q),
        .dout  (out_val)
    );
`else
    assign out_val = fetched;
`endif

    // Reading mem_q (pre-edge contents) gives read-before-write ordering.
    assign fetched    = mem_q[ptr_q];
    assign rd_busy    = (state_q == STREAM);
    assign coef_valid = coef_valid_q;
    assign coef_data  = coef_data_q;
    assign coef_last  = coef_last_q;

    // Write port: out-of-range addresses are dropped.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_addr} < DEPTH_X)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Burst control and output register next-state.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        coef_valid_d = coef_valid_q;
        coef_last_d  = coef_last_q;
        coef_data_d  = coef_data_q;
`ifdef COEF_SAT_SHIFT_EN
        shift_d      = shift_q;
`endif
        base_red  = (rd_base >= DEPTH_A) ? (rd_base - DEPTH_A) : rd_base;
        len_clamp = (rd_len > DEPTH_X) ? DEPTH_X : rd_len;
        start     = (state_q == IDLE) && rd_start && (rd_len != '0);
        load      = (rem_q != '0) && (!coef_valid_q || coef_ready);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    ptr_d   = base_red;
                    rem_d   = len_clamp;
`ifdef COEF_SAT_SHIFT_EN
                    shift_d = rd_shift;
`endif
                end
            end
            STREAM: begin
                if (coef_valid_q && coef_ready && coef_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // rem_q is zero in IDLE, so a load never coincides with a start.
        if (load) begin
            coef_data_d  = out_val;
            coef_valid_d = 1'b1;
            coef_last_d  = (rem_q == (ADDR_W + 1)'(1));
            ptr_d        = (ptr_q == LAST_A) ? '0 : ptr_q + 1'b1;
            rem_d        = rem_q - 1'b1;
        end else if (coef_valid_q && coef_ready) begin
            coef_valid_d = 1'b0;
            coef_last_d  = 1'b0;
        end
    end

    // State, storage and output registers; reset aborts any burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
            coef_data_q  <= '0;
`ifdef COEF_SAT_SHIFT_EN
            shift_q      <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            coef_valid_q <= coef_valid_d;
            coef_last_q  <= coef_last_d;
            coef_data_q  <= coef_data_d;
`ifdef COEF_SAT_SHIFT_EN
            shift_q      <= shift_d;
`endif
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_coef_stream_buf.sv
// Self-checking bench for coef_stream_buf (default DEPTH 40, DATA_W 16).
module tb_coef_stream_buf;

    localparam int DEPTH = 40;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_start;
    logic [5:0]  rd_base;
    logic [6:0]  rd_len;
`ifdef COEF_SAT_SHIFT_EN
    logic [2:0]  rd_shift;
`endif
    logic        rd_busy;
    logic        coef_valid;
    logic        coef_ready;
    logic [15:0] coef_data;
    logic        coef_last;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_mem [DEPTH];

    coef_stream_buf #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_start   (rd_start),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
`ifdef COEF_SAT_SHIFT_EN
        .rd_shift   (rd_shift),
`endif
        .rd_busy    (rd_busy),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_last  (coef_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference value: stored coefficient times 2**sh, clamped to 16-bit signed.
    function automatic logic [15:0] ref_val(input logic [15:0] raw, input int sh);
        longint v;
        v = longint'($signed(raw)) * (longint'(1) << sh);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic wr(input int addr, input logic [15:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr[5:0];
        wr_data = data;
        if (addr < DEPTH) model_mem[addr] = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // rmode: 0 ready always high, 1 random, 2 pattern 1,0,0,1.
    task automatic burst(input int base, input int len, input int rmode,
                         input bit inject, input bit wr_same, input int sh);
        logic [15:0] exp_q[$];
        int b, n, idx, cyc;
        bit r, pv, pr, pl;
        logic [15:0] pd;
        logic [15:0] newv;
        b = (base >= DEPTH) ? base - DEPTH : base;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_val(model_mem[(b + i) % DEPTH], sh));
        newv = ~model_mem[b % DEPTH];
        @(negedge clk);
        rd_start = 1'b1; rd_base = base[5:0]; rd_len = len[6:0]; coef_ready = 1'b0;
`ifdef COEF_SAT_SHIFT_EN
        rd_shift = sh[2:0];
`endif
        @(negedge clk);
        rd_start = 1'b0;
        if (n == 0) begin
            for (int k = 0; k < 3; k++) begin
                chk("len0_busy", rd_busy, 0);
                chk("len0_valid", coef_valid, 0);
                @(negedge clk);
            end
            return;
        end
        chk("busy_after_start", rd_busy, 1);
        chk("valid_edge_n", coef_valid, 0);
        idx = 0; cyc = 0; pv = 0; pr = 0; pd = '0; pl = 0;
        while (idx < n && cyc < 500) begin
            if (cyc == 1) chk("valid_edge_n1", coef_valid, 1);
            if (pv && !pr) begin
                chk("hold_valid", coef_valid, 1);
                chk("hold_data", coef_data, pd);
                chk("hold_last", coef_last, pl);
            end
            wr_en = 1'b0;
            rd_start = 1'b0;
            if (wr_same && cyc == 0) begin
                wr_en = 1'b1; wr_addr = b[5:0]; wr_data = newv;
                model_mem[b] = newv;
            end
            if (inject && cyc == 2) begin
                rd_start = 1'b1;
                rd_base  = 6'($urandom_range(0, 39));
                rd_len   = 7'($urandom_range(1, 40));
            end
            case (rmode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            coef_ready = r;
            if (coef_valid && r) begin
                chk("beat_data", coef_data, exp_q[idx]);
                chk("beat_last", coef_last, (idx == n - 1) ? 1 : 0);
                idx++;
            end
            pv = coef_valid; pr = r; pd = coef_data; pl = coef_last;
            @(negedge clk);
            cyc++;
        end
        rd_start = 1'b0; wr_en = 1'b0; coef_ready = 1'b0;
        chk("beat_count", idx, n);
        chk("busy_end", rd_busy, 0);
        chk("valid_end", coef_valid, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0; coef_ready = 1'b0;
`ifdef COEF_SAT_SHIFT_EN
        rd_shift = '0;
`endif
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", rd_busy, 0);
        chk("rst_valid", coef_valid, 0);
        chk("rst_data", coef_data, 0);
        chk("rst_last", coef_last, 0);
        rst = 1'b0;

        // Zero memory after reset.
        burst(0, 4, 0, 0, 0, 0);

        // Load then stream, two-edge latency.
        wr(0, 16'h0010); wr(1, 16'h0003); wr(2, 16'h0017); wr(3, 16'hfffc);
        burst(0, 4, 0, 0, 0, 0);

        // Wrap with backpressure.
        for (int i = 0; i < DEPTH; i++) wr(i, 16'(i));
        wr(40, 16'h1234); wr(63, 16'h5678);
        burst(38, 5, 2, 0, 0, 0);

        // Length 0, clamp of 63, ignored mid-burst start, base modulo.
        burst(5, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) wr(i, 16'($urandom));
        burst(7, 63, 1, 1, 0, 0);
        burst(45, 6, 1, 0, 0, 0);

        // Write on the same edge as the fetch of that address.
        burst(10, 3, 0, 0, 1, 0);
        burst(10, 1, 0, 0, 0, 0);

        // Random bursts.
        for (int t = 0; t < 6; t++)
            burst($urandom_range(0, 63), $urandom_range(1, 63), 1, 0, 0, 0);

        // Reset mid-burst aborts and clears memory.
        for (int i = 0; i < DEPTH; i++) wr(i, 16'h0100 + 16'(i));
        @(negedge clk);
        rd_start = 1'b1; rd_base = '0; rd_len = 7'd6;
        @(negedge clk);
        rd_start = 1'b0; coef_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", coef_valid, 0);
        chk("midrst_busy", rd_busy, 0);
        chk("midrst_data", coef_data, 0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(negedge clk);
        rst = 1'b0; coef_ready = 1'b0;
        burst(0, 40, 0, 0, 0, 0);

`ifdef COEF_SAT_SHIFT_EN
        wr(0, 16'h003e); wr(1, 16'hff7f); wr(2, 16'h4000); wr(3, 16'h8000);
        burst(0, 2, 0, 0, 0, 3);
        burst(2, 1, 0, 0, 0, 1);
        burst(3, 1, 0, 0, 0, 1);
        for (int t = 0; t < 3; t++)
            burst($urandom_range(0, 39), $urandom_range(1, 10), 1, 0, 0, $urandom_range(0, 7));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
